// File: rtl/pipe_hazard.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stalls, plus a req/ack handshake that holds the pipeline on M-stage memory accesses.
module pipe_hazard #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       memwriteM,
  input  logic       branchD,
  input  logic       dmem_ack,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushE,
  output logic       flushW,
  output logic       dmem_req,
  output logic       dmem_err
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic access_m;
  logic lw_stall;
  logic br_stall;
  logic mem_stall;

  // ALU operand source: M-stage result beats W-stage result; r0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (regwriteM && (src == writeregM)) begin
        sel = 2'b10;
      end else if (regwriteW && (src == writeregW)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(rsE);
    forwardBE = fwd_sel(rtE);
    forwardAD = (rsD != '0) && regwriteM && (rsD == writeregM);
    forwardBD = (rtD != '0) && regwriteM && (rtD == writeregM);
  end

  always_comb begin
    lw_stall = memtoregE && ((rsD == rtE) || (rtD == rtE));
    br_stall = branchD &&
               ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
    access_m  = memtoregM || memwriteM;
    mem_stall = access_m && (state_q != S_DONE);
  end

  // A stalled M stage keeps E held rather than bubbled, so the flush yields to it
  always_comb begin
    stallF   = lw_stall || br_stall || mem_stall;
    stallD   = lw_stall || br_stall || mem_stall;
    stallE   = mem_stall;
    stallM   = mem_stall;
    flushE   = (lw_stall || br_stall) && !mem_stall;
    flushW   = mem_stall;
    dmem_req = mem_stall && !rst;
    dmem_err = err_q;
  end

  // Memory handshake: ack has priority over the timeout on the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (access_m) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard.sv
// Directed and randomized checks of pipe_hazard against a cycle-level reference
// model of the hazard equations and the memory access lifecycle.
module tb_pipe_hazard;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM, memwriteM, branchD, dmem_ack;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushE, flushW, dmem_req, dmem_err;

  int n_vec = 0;
  int n_err = 0;

  // Model of the access in M: busy = request outstanding, done = completion cycle
  bit m_busy, m_done, m_err;
  int m_waits;

  always #5 clk = ~clk;

  pipe_hazard #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .branchD(branchD), .dmem_ack(dmem_ack),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW),
    .dmem_req(dmem_req), .dmem_err(dmem_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (regwriteM && r == writeregM) return 2'b10;
    if (regwriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; memwriteM = 0; branchD = 0; dmem_ack = 0;
  endtask

  // Check every output against the model, advance the model across one edge
  task automatic cycle(input string tag);
    logic acc, lw, br, ms;
    #1;
    acc = memtoregM | memwriteM;
    lw  = memtoregE & (rsD == rtE || rtD == rtE);
    br  = branchD & ((regwriteE & (writeregE == rsD || writeregE == rtD)) |
                     (memtoregM & (writeregM == rsD || writeregM == rtD)));
    ms  = acc & ~m_done;
    chk2({tag, ":forwardAE"}, forwardAE, ref_fwd(rsE));
    chk2({tag, ":forwardBE"}, forwardBE, ref_fwd(rtE));
    chk1({tag, ":forwardAD"}, forwardAD, rsD != 0 && regwriteM && rsD == writeregM);
    chk1({tag, ":forwardBD"}, forwardBD, rtD != 0 && regwriteM && rtD == writeregM);
    chk1({tag, ":stallF"}, stallF, lw | br | ms);
    chk1({tag, ":stallD"}, stallD, lw | br | ms);
    chk1({tag, ":stallE"}, stallE, ms);
    chk1({tag, ":stallM"}, stallM, ms);
    chk1({tag, ":flushE"}, flushE, (lw | br) & ~ms);
    chk1({tag, ":flushW"}, flushW, ms);
    chk1({tag, ":dmem_req"}, dmem_req, ms & ~rst);
    chk1({tag, ":dmem_err"}, dmem_err, m_err);
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_waits = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (dmem_ack) begin
        m_busy = 0; m_done = 1;
      end else if (m_waits + 1 == int'(TO)) begin
        m_busy = 0; m_done = 1; m_err = 1;
      end else begin
        m_waits++;
      end
    end else if (acc) begin
      m_busy = 1; m_waits = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    m_busy = 0; m_done = 0; m_err = 0; m_waits = 0;
    @(negedge clk);
    cycle("reset");

    // Forwarding priority and r0 exclusion
    rst = 0;
    rsE = 5'd5; writeregM = 5'd5; regwriteM = 1; writeregW = 5'd5; regwriteW = 1;
    #1 chk2("fwd_m", forwardAE, 2'b10);
    cycle("fwd_m");
    regwriteM = 0;
    #1 chk2("fwd_w", forwardAE, 2'b01);
    cycle("fwd_w");
    rsE = 5'd0;
    #1 chk2("fwd_r0", forwardAE, 2'b00);
    cycle("fwd_r0");

    // Load-use
    clear_inputs();
    memtoregE = 1; rtE = 5'd8; rsD = 5'd8;
    #1;
    chk1("lw_stallF", stallF, 1'b1);
    chk1("lw_stallD", stallD, 1'b1);
    chk1("lw_flushE", flushE, 1'b1);
    chk1("lw_stallE", stallE, 1'b0);
    cycle("loaduse");

    // Branch hazard, then the producer reaches M as a non-load
    clear_inputs();
    branchD = 1; regwriteE = 1; writeregE = 5'd3; rtD = 5'd3;
    #1;
    chk1("br_stallF", stallF, 1'b1);
    chk1("br_flushE", flushE, 1'b1);
    cycle("branchE");
    regwriteE = 0; writeregE = '0; regwriteM = 1; writeregM = 5'd3;
    #1;
    chk1("brM_stallF", stallF, 1'b0);
    chk1("brM_fwdBD", forwardBD, 1'b1);
    cycle("branchM");

    // Memory wait: ack on the third WAIT cycle
    clear_inputs();
    memtoregM = 1; writeregM = 5'd20;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk1("mw_req", dmem_req, 1'b1);
      chk1("mw_stallM", stallM, 1'b1);
      chk1("mw_flushW", flushW, 1'b1);
      cycle("memwait");
    end
    dmem_ack = 0;
    #1;
    chk1("mw_done_req", dmem_req, 1'b0);
    chk1("mw_done_stallF", stallF, 1'b0);
    chk1("mw_done_stallM", stallM, 1'b0);
    cycle("memdone");
    clear_inputs();
    cycle("idle");

    // Timeout: IDLE + TO WAIT cycles, then DONE with the sticky error
    memwriteM = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("to_req", dmem_req, 1'b1);
      chk1("to_err_low", dmem_err, 1'b0);
      cycle("timeout");
    end
    #1;
    chk1("to_done_req", dmem_req, 1'b0);
    chk1("to_err_set", dmem_err, 1'b1);
    cycle("to_done");
    memwriteM = 0; dmem_ack = 1;
    #1 chk1("to_ack_idle_req", dmem_req, 1'b0);
    cycle("to_ack_idle");
    dmem_ack = 0;
    #1 chk1("to_err_sticky", dmem_err, 1'b1);
    cycle("to_sticky");

    // Reset in the middle of WAIT
    memwriteM = 1;
    #1 chk1("rw_req_idle", dmem_req, 1'b1);
    cycle("rw_idle");
    #1 chk1("rw_req_wait", dmem_req, 1'b1);
    cycle("rw_wait");
    rst = 1;
    #1 chk1("rw_req_rst", dmem_req, 1'b0);
    cycle("rw_rst");
    rst = 0; memwriteM = 0; dmem_ack = 1;
    #1;
    chk1("rw_err_clr", dmem_err, 1'b0);
    chk1("rw_late_ack", dmem_req, 1'b0);
    cycle("rw_late_ack");
    dmem_ack = 0; memwriteM = 1;
    #1 chk1("rw_fresh_req", dmem_req, 1'b1);
    cycle("rw_fresh");
    dmem_ack = 1;
    cycle("rw_ack");
    dmem_ack = 0;
    #1 chk1("rw_fresh_done", stallM, 1'b0);
    cycle("rw_done");
    clear_inputs();
    cycle("idle2");

    // Randomized traffic with small register numbers to provoke matches
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = 1'($urandom_range(0, 1));
      branchD   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        memtoregM = 1'($urandom_range(0, 1));
        memwriteM = 1'($urandom_range(0, 1));
      end
      dmem_ack  = ($urandom_range(0, 2) == 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
